// File: rtl/stepper_if.sv
// Command/status bundle between the move controller and the stepper phase sequencer.
// The master issues moves; the slave (sequencer) reports progress and drives the phase bus.
interface stepper_if #(
  parameter int PERIOD_W = 16,
  parameter int COUNT_W  = 8
);
  logic                start;
  logic                dir;
  logic [COUNT_W-1:0]  steps;
  logic [PERIOD_W-1:0] period;
  logic                abort;
  logic                busy;
  logic                done;
  logic [COUNT_W-1:0]  remaining;
  logic [1:0]          selector;
  logic [3:0]          salida;

  modport master (
    output start, dir, steps, period, abort,
    input  busy, done, remaining, selector, salida
  );

  modport slave (
    input  start, dir, steps, period, abort,
    output busy, done, remaining, selector, salida
  );
endinterface

// File: rtl/stepper_phase_sequencer.sv
// Full-step 4-phase stepper sequencer: accepts a move (steps, dir, period) and
// advances a 2-bit phase selector once per period, decoding it onto a one-hot bus.
module stepper_phase_sequencer #(
  parameter int PERIOD_W = 16,
  parameter int COUNT_W  = 8
) (
  input  logic     clk,
  input  logic     rst_n,
  stepper_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [PERIOD_W-1:0] presc_q, presc_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  logic                dir_q, dir_d;
  logic [COUNT_W-1:0]  remaining_q, remaining_d;
  logic [1:0]          selector_q, selector_d;
  logic                tick;

  assign tick = (presc_q == period_q);

  // NOTE: every output of this block gets a hold default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    presc_d     = presc_q;
    period_d    = period_q;
    dir_d       = dir_q;
    remaining_d = remaining_q;
    selector_d  = selector_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          dir_d       = bus.dir;
          period_d    = bus.period;
          remaining_d = bus.steps;
          presc_d     = '0;
          state_d     = (bus.steps == '0) ? ST_DONE : ST_RUN;
        end
      end

      ST_RUN: begin
        // Abort takes priority over a coincident step tick.
        if (bus.abort) begin
          state_d = ST_IDLE;
        end else if (tick) begin
          presc_d     = '0;
          selector_d  = dir_q ? selector_q + 2'd1 : selector_q - 2'd1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == COUNT_W'(1)) begin
            state_d = ST_DONE;
          end
        end else begin
          presc_d = presc_q + 1'b1;
        end
      end

      ST_DONE: begin
        remaining_d = '0;
        state_d     = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      presc_q     <= '0;
      period_q    <= '0;
      dir_q       <= 1'b0;
      remaining_q <= '0;
      selector_q  <= 2'b00;
    end else begin
      state_q     <= state_d;
      presc_q     <= presc_d;
      period_q    <= period_d;
      dir_q       <= dir_d;
      remaining_q <= remaining_d;
      selector_q  <= selector_d;
    end
  end

  // Phase decode stays live in IDLE so the motor keeps holding torque.
  always_comb begin
    unique case (selector_q)
      2'b00:   bus.salida = 4'b1000;
      2'b01:   bus.salida = 4'b0001;
      2'b10:   bus.salida = 4'b0010;
      default: bus.salida = 4'b0100;
    endcase
  end

  assign bus.busy      = (state_q == ST_RUN);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.remaining = remaining_q;
  assign bus.selector  = selector_q;

endmodule

// File: tb/tb_stepper_phase_sequencer.sv
// Scoreboard bench: each command pushes its expected phase steps; a negedge monitor
// pops and compares them whenever the selector moves.
module tb_stepper_phase_sequencer;
  localparam int PW = 16;
  localparam int CW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stepper_if #(.PERIOD_W(PW), .COUNT_W(CW)) bus ();

  stepper_phase_sequencer #(.PERIOD_W(PW), .COUNT_W(CW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0]    sel;
    logic [3:0]    ph;
    logic [CW-1:0] rem;
  } step_t;

  step_t       exp_q[$];
  int unsigned step_cyc[$];
  step_t       mon_e;
  int          compared   = 0;
  int          mismatched = 0;
  int unsigned cyc        = 0;
  int          done_cnt   = 0;
  logic [1:0]  prev_sel   = 2'b00;
  logic [1:0]  plan_sel   = 2'b00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [3:0] phase_of(input logic [1:0] s);
    case (s)
      2'b00:   return 4'b1000;
      2'b01:   return 4'b0001;
      2'b10:   return 4'b0010;
      default: return 4'b0100;
    endcase
  endfunction

  task automatic plan(input logic d, input int s);
    for (int i = 1; i <= s; i++) begin
      plan_sel = d ? plan_sel + 2'd1 : plan_sel - 2'd1;
      exp_q.push_back('{sel: plan_sel, ph: phase_of(plan_sel), rem: CW'(s - i)});
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && bus.done) done_cnt++;
    if (rst_n && bus.selector !== prev_sel) begin
      if (exp_q.size() == 0) begin
        check("spurious_step", bus.selector, prev_sel);
      end else begin
        mon_e = exp_q.pop_front();
        check("step_sel", bus.selector, mon_e.sel);
        check("step_phase", bus.salida, mon_e.ph);
        check("step_rem", bus.remaining, mon_e.rem);
        step_cyc.push_back(cyc);
      end
    end
    prev_sel = bus.selector;
  end

  task automatic drive_start(input logic d, input int s, input int p, output int unsigned c0);
    @(negedge clk);
    bus.dir    = d;
    bus.steps  = CW'(s);
    bus.period = PW'(p);
    bus.start  = 1'b1;
    c0 = cyc;
    step_cyc.delete();
    plan(d, s);
  endtask

  // Full move with timing checks; poke pulses a conflicting start mid-move (needs p >= 3).
  task automatic run_move(input logic d, input int s, input int p, input bit poke);
    int unsigned c0, done_at;
    int          busy_n, d0;
    bit          got_done;
    d0 = done_cnt;
    busy_n = 0;
    got_done = 1'b0;
    done_at = 0;
    drive_start(d, s, p, c0);
    for (int i = 0; i < s * (p + 1) + 20; i++) begin
      @(negedge clk);
      if (i == 0) bus.start = 1'b0;
      if (poke && i == 1) begin
        bus.start = 1'b1; bus.dir = ~d; bus.steps = '1; bus.period = '0;
      end
      if (poke && i == 2) begin
        bus.start = 1'b0;
        check("ignored_start_rem", bus.remaining, s);
      end
      if (bus.busy) busy_n++;
      else begin
        got_done = bus.done;
        done_at  = cyc;
        break;
      end
    end
    check("busy_cycles", busy_n, s * (p + 1));
    check("done_pulse", got_done, 1);
    check("done_cycle", done_at - c0, s * (p + 1) + 1);
    check("done_remaining", bus.remaining, 0);
    @(negedge clk);
    check("done_width", bus.done, 0);
    check("idle_busy", bus.busy, 0);
    check("done_count", done_cnt - d0, 1);
    check("queue_drained", exp_q.size(), 0);
    check("step_count", step_cyc.size(), s);
    if (step_cyc.size() > 0) check("first_step_latency", step_cyc[0] - c0, p + 2);
    for (int i = 1; i < step_cyc.size(); i++)
      check("step_interval", step_cyc[i] - step_cyc[i-1], p + 1);
  endtask

  task automatic wait_queue(input int target, input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (exp_q.size() <= target) begin ok = 1'b1; break; end
    end
    check(tag, ok, 1);
  endtask

  initial begin
    int unsigned c0;
    int          d0;
    logic [1:0]  hold_sel;
    bus.start = 1'b0; bus.dir = 1'b0; bus.steps = '0; bus.period = '0; bus.abort = 1'b0;

    // Reset and idle hold
    repeat (2) @(negedge clk);
    check("rst_remaining", bus.remaining, 0);
    check("rst_selector", bus.selector, 2'b00);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_selector", bus.selector, 2'b00);
      check("idle_salida", bus.salida, 4'b1000);
      check("idle_busy", bus.busy, 0);
      check("idle_done", bus.done, 0);
    end

    // Forward move, then continuation, then reverse wrap through 00
    run_move(1'b1, 5, 2, 1'b0);
    run_move(1'b1, 3, 0, 1'b0);
    check("pre_reverse_sel", bus.selector, 2'b00);
    run_move(1'b0, 3, 0, 1'b0);

    // Zero-step command
    hold_sel = bus.selector;
    run_move(1'b1, 0, 5, 1'b0);
    check("zero_step_sel", bus.selector, hold_sel);
    check("zero_step_phase", bus.salida, phase_of(hold_sel));

    // Abort after the third step
    d0 = done_cnt;
    hold_sel = plan_sel + 2'd3;
    drive_start(1'b1, 10, 4, c0);
    @(negedge clk); bus.start = 1'b0;
    wait_queue(7, "abort_wait");
    bus.abort = 1'b1;
    @(negedge clk); bus.abort = 1'b0;
    exp_q.delete();
    plan_sel = hold_sel;
    check("abort_busy", bus.busy, 0);
    check("abort_remaining", bus.remaining, 7);
    repeat (10) @(negedge clk);
    check("abort_selector", bus.selector, hold_sel);
    check("abort_no_done", done_cnt - d0, 0);

    // Abort coinciding with the final step tick
    d0 = done_cnt;
    hold_sel = plan_sel;
    drive_start(1'b0, 1, 2, c0);
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk); bus.abort = 1'b1;
    @(negedge clk); bus.abort = 1'b0;
    exp_q.delete();
    plan_sel = hold_sel;
    check("final_abort_busy", bus.busy, 0);
    check("final_abort_remaining", bus.remaining, 1);
    repeat (5) @(negedge clk);
    check("final_abort_selector", bus.selector, hold_sel);
    check("final_abort_no_done", done_cnt - d0, 0);

    // Abort in IDLE is ignored; new command still accepted
    bus.abort = 1'b1;
    @(negedge clk); bus.abort = 1'b0;
    check("idle_abort_sel", bus.selector, hold_sel);
    run_move(1'b1, 2, 1, 1'b0);

    // Start during RUN is ignored
    run_move(1'b1, 4, 3, 1'b1);

    // Reset mid-move
    d0 = done_cnt;
    drive_start(1'b1, 6, 1, c0);
    @(negedge clk); bus.start = 1'b0;
    wait_queue(4, "reset_wait");
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    plan_sel = 2'b00;
    #1;
    check("midrst_selector", bus.selector, 2'b00);
    check("midrst_salida", bus.salida, 4'b1000);
    check("midrst_busy", bus.busy, 0);
    check("midrst_done", bus.done, 0);
    check("midrst_remaining", bus.remaining, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("midrst_no_done", done_cnt - d0, 0);
    check("midrst_idle", bus.busy, 0);
    run_move(1'b1, 1, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
    $fatal(1);
  end

endmodule
